// File: rtl/cnn_pkg.sv
// Shared constants, data type and signed max helper for the CNN pooling path.
// Package cnn_pkg: ACCW, IN_W, POOL_W, data_t, max2.
package cnn_pkg;

    localparam int ACCW   = 32;
    localparam int IN_W   = 26;
    localparam int POOL_W = IN_W / 2;

    typedef logic signed [ACCW-1:0] data_t;

    function automatic data_t max2(input data_t a, input data_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_lane.sv
// One lane of ReLU + 2x2 max-pool: hold register, half-row line buffer, final max.
// ReLU is applied only when POOL_RELU_EN is defined.
module pool_lane
    import cnn_pkg::*;
#(
    parameter int ACCW   = cnn_pkg::ACCW,
    parameter int POOL_W = cnn_pkg::POOL_W
) (
    input  logic                   iClk,
    input  logic                   iAcc,
    input  logic                   iRowOdd,
    input  logic                   iColOdd,
    input  logic [3:0]             iIdx,
    input  logic signed [ACCW-1:0] iX,
    output logic signed [ACCW-1:0] oRes
);

    localparam int IW = (POOL_W > 1) ? $clog2(POOL_W) : 1;

    logic signed [ACCW-1:0] hold_q, hold_d;
    logic signed [ACCW-1:0] lbuf_q [POOL_W];
    logic signed [ACCW-1:0] lbuf_d [POOL_W];
    logic signed [ACCW-1:0] r;
    logic signed [ACCW-1:0] h;
    logic signed [ACCW-1:0] lb;
    logic [IW-1:0]          idx;

    // Rectify the input, fold the horizontal pair, then the vertical pair.
    always_comb begin
`ifdef POOL_RELU_EN
        r = iX[ACCW-1] ? '0 : iX;
`else
        r = iX;
`endif
        idx  = iIdx[IW-1:0];
        h    = (hold_q > r) ? hold_q : r;
        lb   = lbuf_q[idx];
        oRes = (lb > h) ? lb : h;
    end

    // Even column loads the hold register; even row, odd column fills the line buffer.
    always_comb begin
        hold_d = hold_q;
        lbuf_d = lbuf_q;
        if (iAcc && !iColOdd) begin
            hold_d = r;
        end
        if (iAcc && !iRowOdd && iColOdd) begin
            lbuf_d[idx] = h;
        end
    end

    // Pooling storage; every entry is rewritten before it is read, so no reset.
    always_ff @(posedge iClk) begin
        hold_q <= hold_d;
        lbuf_q <= lbuf_d;
    end

endmodule

// File: rtl/relu_maxpool2x2_x4.sv
// Four-lane ReLU + 2x2/stride-2 max-pool with row/col tags, frame done and format error.
// Optional ReLU enabled by defining POOL_RELU_EN.
module relu_maxpool2x2_x4
    import cnn_pkg::*;
#(
    parameter int ACCW = cnn_pkg::ACCW,
    parameter int IN_W = cnn_pkg::IN_W
) (
    input  logic                   iClk,
    input  logic                   iRsn,
    input  logic [3:0]             iValid,
    input  logic signed [ACCW-1:0] iData0,
    input  logic signed [ACCW-1:0] iData1,
    input  logic signed [ACCW-1:0] iData2,
    input  logic signed [ACCW-1:0] iData3,
    input  logic                   iSof,
    output logic                   oValid,
    output logic signed [ACCW-1:0] oData0,
    output logic signed [ACCW-1:0] oData1,
    output logic signed [ACCW-1:0] oData2,
    output logic signed [ACCW-1:0] oData3,
    output logic [3:0]             oRow,
    output logic [3:0]             oCol,
    output logic                   oFrameDone,
    output logic                   oFmtErr
);

    localparam int POOL_W = IN_W / 2;
    localparam int CW     = (IN_W > 2) ? $clog2(IN_W) : 1;

    logic [CW-1:0] row_q, row_d, col_q, col_d;
    logic [CW-1:0] cur_row, cur_col;
    logic          acc, fmt_bad, emit, last_row, last_col;

    logic                   valid_q, valid_d;
    logic                   fdone_q, fdone_d;
    logic                   err_q, err_d;
    logic [3:0]             orow_q, orow_d, ocol_q, ocol_d;
    logic signed [ACCW-1:0] data_q [4];
    logic signed [ACCW-1:0] data_d [4];
    logic signed [ACCW-1:0] lane_x [4];
    logic signed [ACCW-1:0] lane_res [4];

    assign lane_x[0] = iData0;
    assign lane_x[1] = iData1;
    assign lane_x[2] = iData2;
    assign lane_x[3] = iData3;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        pool_lane #(
            .ACCW   (ACCW),
            .POOL_W (POOL_W)
        ) u_lane (
            .iClk    (iClk),
            .iAcc    (acc),
            .iRowOdd (cur_row[0]),
            .iColOdd (cur_col[0]),
            .iIdx    (4'(cur_col >> 1)),
            .iX      (lane_x[g]),
            .oRes    (lane_res[g])
        );
    end

    // Beat qualification, position tracking and next output register values.
    always_comb begin
        acc      = (iValid == 4'hF);
        fmt_bad  = (iValid != 4'h0) && !acc;
        cur_row  = iSof ? '0 : row_q;
        cur_col  = iSof ? '0 : col_q;
        last_row = (cur_row == CW'(IN_W - 1));
        last_col = (cur_col == CW'(IN_W - 1));
        emit     = acc && cur_row[0] && cur_col[0];

        row_d = row_q;
        col_d = col_q;
        if (acc) begin
            col_d = last_col ? '0 : cur_col + 1'b1;
            if (last_col) begin
                row_d = last_row ? '0 : cur_row + 1'b1;
            end else begin
                row_d = cur_row;
            end
        end

        valid_d = emit;
        fdone_d = emit && last_row && last_col;
        err_d   = err_q || fmt_bad;
        orow_d  = orow_q;
        ocol_d  = ocol_q;
        data_d  = data_q;
        if (emit) begin
            orow_d = 4'(cur_row >> 1);
            ocol_d = 4'(cur_col >> 1);
            data_d = lane_res;
        end
    end

    // Counters and registered outputs with synchronous active-low reset.
    always_ff @(posedge iClk) begin
        if (!iRsn) begin
            row_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b0;
            fdone_q <= 1'b0;
            err_q   <= 1'b0;
            orow_q  <= '0;
            ocol_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            valid_q <= valid_d;
            fdone_q <= fdone_d;
            err_q   <= err_d;
            orow_q  <= orow_d;
            ocol_q  <= ocol_d;
            data_q  <= data_d;
        end
    end

    assign oValid     = valid_q;
    assign oFrameDone = fdone_q;
    assign oFmtErr    = err_q;
    assign oRow       = orow_q;
    assign oCol       = ocol_q;
    assign oData0     = data_q[0];
    assign oData1     = data_q[1];
    assign oData2     = data_q[2];
    assign oData3     = data_q[3];

endmodule
